// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared FP16 types and widths for the PE floating-point unit.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int FP16_W  = 16;
    localparam int FLAGS_W = 4;

    typedef logic [FP16_W-1:0] fp16_t;

    // Bit order matches the rsp_flags vector: {overflow, underflow, inexact, cout}
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic cout;
    } fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
// Module   : fp_add
// Purpose  : Combinational FP16 adder. Subnormal inputs/results flush to zero,
//            the fraction is truncated, overflow saturates to infinity.
//            inexact is reported whenever a nonzero operand had to be aligned
//            or a normalisation carry dropped a set bit. cout marks an
//            exponent carry-out caused by the significand carry.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add
    import fpu_pkg::*;
(
    input  fp16_t     a,
    input  fp16_t     b,
    output fp16_t     sum,
    output fp_flags_t flags
);

    fp16_t       op_l;
    fp16_t       op_s;
    logic        sl;
    logic        ss;
    logic        eff_sub;
    logic        lz_found;
    logic [4:0]  el;
    logic [4:0]  es;
    logic [4:0]  ediff;
    logic [10:0] ml;
    logic [10:0] ms;
    logic [10:0] ms_al;
    logic [11:0] mag;
    logic [9:0]  frac;
    int          lz;
    int          e_res;

    // Order by magnitude so the aligned subtraction can never go negative
    always_comb begin
        op_l    = (a[14:0] >= b[14:0]) ? a : b;
        op_s    = (a[14:0] >= b[14:0]) ? b : a;
        sl      = op_l[15];
        ss      = op_s[15];
        el      = op_l[14:10];
        es      = op_s[14:10];
        ml      = (el != 5'd0) ? {1'b1, op_l[9:0]} : 11'd0;
        ms      = (es != 5'd0) ? {1'b1, op_s[9:0]} : 11'd0;
        ediff   = el - es;
        ms_al   = ms >> ediff;
        eff_sub = sl ^ ss;
    end

    // Add/subtract aligned significands, normalise, then pack and flag
    always_comb begin
        sum      = '0;
        flags    = '0;
        lz       = 0;
        lz_found = 1'b0;
        e_res    = 0;
        frac     = '0;
        mag      = eff_sub ? ({1'b0, ml} - {1'b0, ms_al}) : ({1'b0, ml} + {1'b0, ms_al});
        flags.inexact = (ediff != 5'd0) && (ms != 11'd0);

        if (mag[11]) begin
            e_res         = int'(el) + 1;
            frac          = mag[10:1];
            flags.inexact = flags.inexact | mag[0];
            flags.cout    = (e_res >= 31);
        end else begin
            for (int i = 10; i >= 0; i--) begin
                if (!lz_found && mag[i]) begin
                    lz       = 10 - i;
                    lz_found = 1'b1;
                end
            end
            e_res = int'(el) - lz;
            frac  = 10'(mag[10:0] << lz);
        end

        if (mag == 12'd0) begin
            sum = {sl & ~eff_sub, 15'd0};
        end else if (e_res >= 31) begin
            flags.overflow = 1'b1;
            sum            = {sl, 5'h1F, 10'd0};
        end else if (e_res <= 0) begin
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
            sum             = {sl, 15'd0};
        end else begin
            sum = {sl, 5'(e_res), frac};
        end

        // Infinity/NaN operands bypass the datapath
        if (el == 5'h1F) begin
            flags = '0;
            if ((op_l[9:0] != 10'd0) || ((es == 5'h1F) && eff_sub)) begin
                sum = 16'h7E00;
            end else begin
                sum = op_l;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Search starts one past ptr and
//            wraps; the first active requester gets a one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Rotating-priority scan: candidates ptr+1, ptr+2, ... ptr (mod N)
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_arbiter
// Purpose  : Shares one FP16 adder between NUM_REQ requesters. Round-robin
//            grant into an operand stage, adder, result stage; tagged response
//            with backpressure and per-requester sticky flag accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_arbiter
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TAG_W   = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][FP16_W-1:0]   req_opA,
    input  logic [NUM_REQ-1:0][FP16_W-1:0]   req_opB,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [TAG_W-1:0]                 rsp_tag,
    output logic [FP16_W-1:0]                rsp_sum,
    output logic [FLAGS_W-1:0]               rsp_flags,
    output logic [NUM_REQ-1:0][FLAGS_W-1:0]  flag_accum,
    input  logic [NUM_REQ-1:0]               flag_clr,
    output logic                             busy
);

    // Operand stage
    logic                 s1_valid_q, s1_valid_d;
    fp16_t                s1_opa_q,   s1_opa_d;
    fp16_t                s1_opb_q,   s1_opb_d;
    logic [TAG_W-1:0]     s1_tag_q,   s1_tag_d;
    logic [ID_W-1:0]      s1_id_q,    s1_id_d;

    // Result stage
    logic                 s2_valid_q, s2_valid_d;
    fp16_t                s2_sum_q,   s2_sum_d;
    logic [FLAGS_W-1:0]   s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0]     s2_tag_q,   s2_tag_d;
    logic [ID_W-1:0]      s2_id_q,    s2_id_d;

    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [NUM_REQ-1:0][FLAGS_W-1:0] flag_accum_q, flag_accum_d;

    logic               s1_adv;
    logic               s2_adv;
    logic               accept;
    logic               retire;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    fp16_t              add_sum;
    fp_flags_t          add_flags;

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    fp_add u_add (
        .a     (s1_opa_q),
        .b     (s1_opb_q),
        .sum   (add_sum),
        .flags (add_flags)
    );

    // Stage advance, handshakes; ready/valid are forced low while in reset
    always_comb begin
        s2_adv    = !s2_valid_q || rsp_ready;
        s1_adv    = !s1_valid_q || s2_adv;
        req_ready = (reset_n && s1_adv) ? gnt : '0;
        accept    = |req_ready;
        rsp_valid = s2_valid_q && reset_n;
        retire    = rsp_valid && rsp_ready;
        busy      = s1_valid_q || s2_valid_q;
    end

    // Next-state for pipeline stages, arbitration pointer and flag accumulators
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_opa_d     = s1_opa_q;
        s1_opb_d     = s1_opb_q;
        s1_tag_d     = s1_tag_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_sum_d     = s2_sum_q;
        s2_flags_d   = s2_flags_q;
        s2_tag_d     = s2_tag_q;
        s2_id_d      = s2_id_q;
        ptr_d        = ptr_q;
        flag_accum_d = flag_accum_q;

        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_opa_d = req_opA[gnt_idx];
                s1_opb_d = req_opB[gnt_idx];
                s1_tag_d = req_tag[gnt_idx];
                s1_id_d  = gnt_idx;
                ptr_d    = gnt_idx;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d   = add_sum;
                s2_flags_d = add_flags;
                s2_tag_d   = s1_tag_q;
                s2_id_d    = s1_id_q;
            end
        end

        // Clear first so flags retiring in the same cycle survive the clear
        for (int i = 0; i < NUM_REQ; i++) begin
            flag_accum_d[i] = flag_clr[i] ? '0 : flag_accum_q[i];
            if (retire && (s2_id_q == ID_W'(i))) begin
                flag_accum_d[i] = flag_accum_d[i] | s2_flags_q;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_opa_q     <= '0;
            s1_opb_q     <= '0;
            s1_tag_q     <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_flags_q   <= '0;
            s2_tag_q     <= '0;
            s2_id_q      <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            flag_accum_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_opa_q     <= s1_opa_d;
            s1_opb_q     <= s1_opb_d;
            s1_tag_q     <= s1_tag_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_q     <= s2_sum_d;
            s2_flags_q   <= s2_flags_d;
            s2_tag_q     <= s2_tag_d;
            s2_id_q      <= s2_id_d;
            ptr_q        <= ptr_d;
            flag_accum_q <= flag_accum_d;
        end
    end

    assign rsp_id     = s2_id_q;
    assign rsp_tag    = s2_tag_q;
    assign rsp_sum    = s2_sum_q;
    assign rsp_flags  = s2_flags_q;
    assign flag_accum = flag_accum_q;

endmodule
`default_nettype wire
